mem_perf_monitor: RTL and testbench

Synthesizable performance and protocol monitor that sits alongside `mem_system` and consumes its request/reply signals (`Rd`, `Wr`, `Addr`, `Done`, `CacheHit`). It tracks one outstanding request at a time, measures request-to-`Done` latency, and counts requests, replies and hits. It flags latency and handshake violations in hardware, so perf checks also run in emulation and full-processor sims, not only in the memory bench.

---
 rtl/mem_perf_pkg.sv | 25 ++
 rtl/mem_perf_monitor_if.sv | 25 ++
 rtl/mem_perf_lat_ctr.sv | 41 ++++
 rtl/mem_perf_monitor.sv | 157 +++++++++++++++
 tb/tb_mem_perf_monitor.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_perf_pkg.sv
// Shared definitions for the mem_system performance monitor:
//   - state_e     : tracker state (IDLE / BUSY)
//   - DEF_*       : default latency limits and timeout
//   - ERR_*       : bit positions inside the sticky error vector
package mem_perf_pkg;

  localparam int ADDR_W = 16;

  localparam int DEF_HIT_MAX  = 2;
  localparam int DEF_MISS_MAX = 20;
  localparam int DEF_TIMEOUT  = 255;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int ERR_PERF = 0;
  localparam int ERR_DROP = 1;
  localparam int ERR_SPUR = 2;
  localparam int ERR_RDWR = 3;
  localparam int ERR_TMO  = 4;
  localparam int ERR_N    = 5;

endpackage

// File: rtl/mem_perf_monitor_if.sv
// Request/reply bus between a requester and mem_system, as observed by the
// performance monitor.
//   Rd, Wr    : request strobes
//   Addr      : request address
//   Done      : reply strobe from mem_system
//   CacheHit  : qualifies Done, high when the access hit in the cache
//
// Handshake: Rd|Wr acts as the request valid; once raised, Rd, Wr and Addr
// must hold steady until the posedge where Done is sampled high. Done is the
// reply (ready) and completes the request on that posedge; it may coincide
// with the issuing posedge. Only one request is outstanding at a time.
interface mem_perf_monitor_if;
  import mem_perf_pkg::*;

  logic              Rd;
  logic              Wr;
  logic [ADDR_W-1:0] Addr;
  logic              Done;
  logic              CacheHit;

  // master: side that drives the bus (requester + memory)
  modport master (output Rd, Wr, Addr, Done, CacheHit);
  // slave: passive observer (the monitor)
  modport slave  (input  Rd, Wr, Addr, Done, CacheHit);
endinterface

// File: rtl/mem_perf_lat_ctr.sv
// Latency counter for the outstanding request.
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : synchronous clear to 0
//   load_i     : load 1 (the issuing cycle counts as latency 1)
//   inc_i      : increment by one
//   lat_o      : current count
//   at_tmo_o   : high when one more cycle would reach TIMEOUT
module mem_perf_lat_ctr #(
  parameter int LAT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [LAT_W-1:0] lat_o,
  output logic             at_tmo_o
);

  localparam logic [LAT_W-1:0] TMO_M1 = LAT_W'(TIMEOUT - 1);

  logic [LAT_W-1:0] lat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q <= '0;
    end else if (clr_i) begin
      lat_q <= '0;
    end else if (load_i) begin
      lat_q <= LAT_W'(1);
    end else if (inc_i) begin
      lat_q <= lat_q + LAT_W'(1);
    end
  end

  assign lat_o    = lat_q;
  // The owner stops incrementing when this is high, so lat_q never wraps.
  assign at_tmo_o = (lat_q == TMO_M1);

endmodule

// File: rtl/mem_perf_monitor.sv
// Passive performance/protocol monitor for mem_system.
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : synchronous clear of counters, latencies and flags
//   bus             : observed request/reply bus (slave modport)
//   n_requests      : issued requests
//   n_replies       : completed requests
//   n_hits          : completed requests that hit
//   last_lat        : latency of the latest completed request
//   max_lat         : largest latency seen
//   err_perf/drop/spur/rdwr/tmo : sticky error flags
//   err_any         : OR of all error flags
//   dbg_state_o     : tracker state
module mem_perf_monitor
  import mem_perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int LAT_W    = 8,
  parameter int HIT_MAX  = DEF_HIT_MAX,
  parameter int MISS_MAX = DEF_MISS_MAX,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  mem_perf_monitor_if.slave   bus,
  output logic [CNT_W-1:0]    n_requests,
  output logic [CNT_W-1:0]    n_replies,
  output logic [CNT_W-1:0]    n_hits,
  output logic [LAT_W-1:0]    last_lat,
  output logic [LAT_W-1:0]    max_lat,
  output logic                err_perf,
  output logic                err_drop,
  output logic                err_spur,
  output logic                err_rdwr,
  output logic                err_tmo,
  output logic                err_any,
  output state_e              dbg_state_o
);

  localparam logic [LAT_W-1:0] HIT_LIM  = LAT_W'(HIT_MAX);
  localparam logic [LAT_W-1:0] MISS_LIM = LAT_W'(MISS_MAX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_req_q, n_rep_q, n_hit_q;
  logic [LAT_W-1:0]  last_lat_q, max_lat_q;
  logic [ERR_N-1:0]  err_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q, wr_q;

  logic [LAT_W-1:0]  lat;
  logic              at_tmo;

  logic              req, is_idle, changed;
  logic              issue, complete, drop, tmo, spur, rdwr;
  logic              perf_bad, lat_load, lat_inc;
  logic [LAT_W-1:0]  cur_lat;

  always_comb begin
    req      = bus.Rd | bus.Wr;
    is_idle  = (state_q == IDLE);
    changed  = (bus.Addr != addr_q) | (bus.Rd != rd_q) | (bus.Wr != wr_q);

    issue    = is_idle & req;
    // Done while busy completes even if the request changed on the same
    // cycle; Done on the issuing cycle completes immediately.
    complete = (issue & bus.Done) | (~is_idle & bus.Done);
    drop     = ~is_idle & ~bus.Done & (~req | changed);
    tmo      = ~is_idle & ~bus.Done & ~drop & at_tmo;
    spur     = is_idle & ~req & bus.Done;
    rdwr     = bus.Rd & bus.Wr;

    // lat counts cycles already spent; the completing cycle adds one more.
    cur_lat  = is_idle ? LAT_W'(1) : lat + LAT_W'(1);
    perf_bad = bus.CacheHit ? (cur_lat > HIT_LIM)
                            : ((cur_lat <= HIT_LIM) | (cur_lat > MISS_LIM));

    lat_load = ~clr & issue;
    lat_inc  = ~clr & ~is_idle & ~bus.Done & ~drop & ~at_tmo;

    state_d = state_q;
    if (is_idle) begin
      if (issue && !bus.Done) state_d = BUSY;
    end else if (complete || drop || tmo) begin
      state_d = IDLE;
    end
  end

  mem_perf_lat_ctr #(
    .LAT_W   (LAT_W),
    .TIMEOUT (TIMEOUT)
  ) u_lat_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .load_i   (lat_load),
    .inc_i    (lat_inc),
    .lat_o    (lat),
    .at_tmo_o (at_tmo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_req_q    <= '0;
      n_rep_q    <= '0;
      n_hit_q    <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
      err_q      <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else if (clr) begin
      // clr wins over every same-cycle event, which is discarded.
      state_q    <= IDLE;
      n_req_q    <= '0;
      n_rep_q    <= '0;
      n_hit_q    <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
      err_q      <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        n_req_q <= n_req_q + CNT_W'(1);
        addr_q  <= bus.Addr;
        rd_q    <= bus.Rd;
        wr_q    <= bus.Wr;
      end
      if (complete) begin
        n_rep_q    <= n_rep_q + CNT_W'(1);
        if (bus.CacheHit) n_hit_q <= n_hit_q + CNT_W'(1);
        last_lat_q <= cur_lat;
        if (cur_lat > max_lat_q) max_lat_q <= cur_lat;
        if (perf_bad) err_q[ERR_PERF] <= 1'b1;
      end
      if (drop) err_q[ERR_DROP] <= 1'b1;
      if (tmo)  err_q[ERR_TMO]  <= 1'b1;
      if (spur) err_q[ERR_SPUR] <= 1'b1;
      if (rdwr) err_q[ERR_RDWR] <= 1'b1;
    end
  end

  assign n_requests  = n_req_q;
  assign n_replies   = n_rep_q;
  assign n_hits      = n_hit_q;
  assign last_lat    = last_lat_q;
  assign max_lat     = max_lat_q;
  assign err_perf    = err_q[ERR_PERF];
  assign err_drop    = err_q[ERR_DROP];
  assign err_spur    = err_q[ERR_SPUR];
  assign err_rdwr    = err_q[ERR_RDWR];
  assign err_tmo     = err_q[ERR_TMO];
  assign err_any     = |err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_perf_monitor.sv
// Self-checking bench for mem_perf_monitor: directed scenarios followed by
// randomized request traffic, scored against a cycle-indexed request model.
module tb_mem_perf_monitor;
  import mem_perf_pkg::*;

  localparam int M_HIT_MAX  = 2;
  localparam int M_MISS_MAX = 20;
  localparam int M_TIMEOUT  = 255;

  typedef struct packed {
    logic [31:0] n_req;
    logic [31:0] n_rep;
    logic [31:0] n_hit;
    logic [7:0]  last;
    logic [7:0]  maxl;
    logic        perf;
    logic        drop;
    logic        spur;
    logic        rdwr;
    logic        tmo;
    logic        any;
    logic        busy;
  } snap_t;

  localparam int SNAP_W = $bits(snap_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  mem_perf_monitor_if bus();

  logic [31:0] n_requests, n_replies, n_hits;
  logic [7:0]  last_lat, max_lat;
  logic        err_perf, err_drop, err_spur, err_rdwr, err_tmo, err_any;
  state_e      dbg_state;

  mem_perf_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .bus         (bus),
    .n_requests  (n_requests),
    .n_replies   (n_replies),
    .n_hits      (n_hits),
    .last_lat    (last_lat),
    .max_lat     (max_lat),
    .err_perf    (err_perf),
    .err_drop    (err_drop),
    .err_spur    (err_spur),
    .err_rdwr    (err_rdwr),
    .err_tmo     (err_tmo),
    .err_any     (err_any),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [SNAP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.n_req = n_requests; s.n_rep = n_replies; s.n_hit = n_hits;
    s.last  = last_lat;   s.maxl  = max_lat;
    s.perf  = err_perf;   s.drop  = err_drop;  s.spur = err_spur;
    s.rdwr  = err_rdwr;   s.tmo   = err_tmo;   s.any  = err_any;
    s.busy  = (dbg_state == BUSY);
    return s;
  endfunction

  task automatic check_snap(input string tag, input snap_t e);
    snap_t a;
    a = dut_snap();
    chk({tag, ".n_requests"}, a.n_req, e.n_req);
    chk({tag, ".n_replies"},  a.n_rep, e.n_rep);
    chk({tag, ".n_hits"},     a.n_hit, e.n_hit);
    chk({tag, ".last_lat"},   32'(a.last), 32'(e.last));
    chk({tag, ".max_lat"},    32'(a.maxl), 32'(e.maxl));
    chk({tag, ".err_perf"},   32'(a.perf), 32'(e.perf));
    chk({tag, ".err_drop"},   32'(a.drop), 32'(e.drop));
    chk({tag, ".err_spur"},   32'(a.spur), 32'(e.spur));
    chk({tag, ".err_rdwr"},   32'(a.rdwr), 32'(e.rdwr));
    chk({tag, ".err_tmo"},    32'(a.tmo),  32'(e.tmo));
    chk({tag, ".err_any"},    32'(a.any),  32'(e.any));
    chk({tag, ".busy"},       32'(a.busy), 32'(e.busy));
  endtask

  // ---------------- reference model ----------------
  // The outstanding request is remembered by the cycle it issued on; its
  // latency is simply (current cycle - issue cycle + 1).
  logic [31:0] m_req, m_rep, m_hit;
  int          m_last, m_max;
  bit          m_perf, m_drop, m_spur, m_rdwr, m_tmo;
  bit          m_busy, m_rd, m_wr;
  logic [15:0] m_addr;
  int          m_issue, m_cyc;

  task automatic model_reset();
    m_req = 0; m_rep = 0; m_hit = 0; m_last = 0; m_max = 0;
    m_perf = 0; m_drop = 0; m_spur = 0; m_rdwr = 0; m_tmo = 0;
    m_busy = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_issue = 0; m_cyc = 0;
  endtask

  task automatic model_complete(input int l, input bit hit);
    m_rep++;
    if (hit) m_hit++;
    m_last = l;
    if (l > m_max) m_max = l;
    if (hit ? (l > M_HIT_MAX) : (l <= M_HIT_MAX || l > M_MISS_MAX)) m_perf = 1;
  endtask

  task automatic model_step(input bit c, input bit r, input bit w,
                            input logic [15:0] a, input bit d, input bit h);
    int l;
    if (c) begin
      m_req = 0; m_rep = 0; m_hit = 0; m_last = 0; m_max = 0;
      m_perf = 0; m_drop = 0; m_spur = 0; m_rdwr = 0; m_tmo = 0; m_busy = 0;
    end else begin
      if (r && w) m_rdwr = 1;
      if (!m_busy) begin
        if (r || w) begin
          m_req++;
          m_addr = a; m_rd = r; m_wr = w; m_issue = m_cyc;
          if (d) model_complete(1, h);
          else   m_busy = 1;
        end else if (d) begin
          m_spur = 1;
        end
      end else begin
        l = m_cyc - m_issue + 1;
        if (d) begin
          model_complete(l, h);
          m_busy = 0;
        end else if (!(r || w) || a != m_addr || r != m_rd || w != m_wr) begin
          m_drop = 1; m_busy = 0;
        end else if (l >= M_TIMEOUT) begin
          m_tmo = 1; m_busy = 0;
        end
      end
    end
    m_cyc++;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.n_req = m_req; s.n_rep = m_rep; s.n_hit = m_hit;
    s.last = 8'(m_last); s.maxl = 8'(m_max);
    s.perf = m_perf; s.drop = m_drop; s.spur = m_spur; s.rdwr = m_rdwr; s.tmo = m_tmo;
    s.any  = m_perf | m_drop | m_spur | m_rdwr | m_tmo;
    s.busy = m_busy;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit c, input bit r, input bit w,
                       input logic [15:0] a, input bit d, input bit h);
    @(negedge clk);
    clr = c; bus.Rd = r; bus.Wr = w; bus.Addr = a; bus.Done = d; bus.CacheHit = h;
    model_step(c, r, w, a, d, h);
    exp_q.push_back(model_snap());
  endtask

  task automatic idle();
    drive(0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic txn(input bit r, input bit w, input logic [15:0] a, input int lat, input bit h);
    if (lat <= 1) begin
      drive(0, r, w, a, 1, h);
    end else begin
      drive(0, r, w, a, 0, 0);
      for (int i = 0; i < lat - 2; i++) drive(0, r, w, a, 0, 0);
      drive(0, r, w, a, 1, h);
    end
    idle();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_snap("rst_async", model_snap());
    chk("rst_async.n_requests_zero", n_requests, 32'd0);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = snap_t'(exp_q.pop_front());
        check_snap("scb", e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind, sel, lat, guard;
    bit r, w;
    logic [15:0] a;

    bus.Rd = 0; bus.Wr = 0; bus.Addr = 0; bus.Done = 0; bus.CacheHit = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_snap("reset", model_snap());

    // read hit, Done one cycle after issue
    drive(1, 0, 0, 0, 0, 0);
    txn(1, 0, 16'h0100, 2, 1);
    settle();
    chk("hit_lat2.last_lat", 32'(last_lat), 32'd2);
    chk("hit_lat2.n_hits", n_hits, 32'd1);
    chk("hit_lat2.err_perf", 32'(err_perf), 32'd0);

    // write miss at latency 5, then a hit at latency 3
    drive(1, 0, 0, 0, 0, 0);
    txn(0, 1, 16'h0200, 5, 0);
    settle();
    chk("miss5.n_replies", n_replies, 32'd1);
    chk("miss5.n_hits", n_hits, 32'd0);
    chk("miss5.last_lat", 32'(last_lat), 32'd5);
    chk("miss5.max_lat", 32'(max_lat), 32'd5);
    chk("miss5.err_any", 32'(err_any), 32'd0);
    txn(1, 0, 16'h0204, 3, 1);
    settle();
    chk("hit3.err_perf", 32'(err_perf), 32'd1);
    chk("hit3.max_lat", 32'(max_lat), 32'd5);

    // miss latency limits
    drive(1, 0, 0, 0, 0, 0);
    txn(1, 0, 16'h0300, 21, 0);
    settle();
    chk("miss21.err_perf", 32'(err_perf), 32'd1);
    drive(1, 0, 0, 0, 0, 0);
    txn(1, 0, 16'h0304, 2, 0);
    settle();
    chk("miss2.err_perf", 32'(err_perf), 32'd1);

    // address change while busy, then spurious Done
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 16'h0010, 0, 0);
    drive(0, 1, 0, 16'h0010, 0, 0);
    drive(0, 1, 0, 16'h0012, 0, 0);
    idle();
    settle();
    chk("drop.err_drop", 32'(err_drop), 32'd1);
    chk("drop.n_requests", n_requests, 32'd1);
    chk("drop.n_replies", n_replies, 32'd0);
    drive(0, 0, 0, 16'h0, 1, 0);
    idle();
    settle();
    chk("spur.err_spur", 32'(err_spur), 32'd1);

    // timeout with Rd held, then a normal request
    drive(1, 0, 0, 0, 0, 0);
    repeat (255) drive(0, 1, 0, 16'h0040, 0, 0);
    settle();
    chk("tmo.err_tmo", 32'(err_tmo), 32'd1);
    chk("tmo.idle", 32'(dbg_state == IDLE), 32'd1);
    chk("tmo.n_replies", n_replies, 32'd0);
    txn(1, 0, 16'h0040, 4, 0);
    settle();
    chk("after_tmo.n_requests", n_requests, 32'd2);
    chk("after_tmo.last_lat", 32'(last_lat), 32'd4);

    // async reset mid-request, then clr coinciding with Done
    drive(0, 1, 0, 16'h0080, 0, 0);
    drive(0, 1, 0, 16'h0080, 0, 0);
    pulse_rst();
    drive(0, 1, 0, 16'h0080, 0, 0);
    drive(1, 1, 0, 16'h0080, 1, 1);
    idle();
    settle();
    chk("clr_done.n_replies", n_replies, 32'd0);
    chk("clr_done.n_requests", n_requests, 32'd0);

    // randomized traffic
    for (int it = 0; it < 90; it++) begin
      kind = $urandom_range(0, 19);
      sel  = $urandom_range(0, 9);
      r = (sel == 0) || (sel < 5);
      w = (sel == 0) || (sel >= 5);
      a = 16'($urandom_range(0, 65535));
      case (kind)
        0: drive(1, r, w, a, $urandom_range(0, 1), 0);
        1: begin drive(0, 0, 0, a, 1, 1'($urandom_range(0, 1))); idle(); end
        2: begin drive(0, r, w, a, 0, 0); drive(0, r, w, a ^ 16'h0001, 0, 0); idle(); end
        3: begin drive(0, r, w, a, 0, 0); idle(); end
        default: begin
          lat = $urandom_range(1, 24);
          txn(r, w, a, lat, 1'($urandom_range(0, 1)));
        end
      endcase
    end
    idle();

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      settle();
      guard++;
    end
    chk("scb.drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
